// File: rtl/uart_rx_ovs.sv
// UART receiver with a 2-flop synchroniser, 3-sample majority vote per bit, parity/framing/break
// detection and a show-ahead output FIFO with a valid/ready handshake.
module uart_rx_ovs #(
    parameter int CLK_FREQ_HZ     = 100_000_000,
    parameter int BAUD_RATE       = 1_562_500,
    parameter int OVERSAMPLE_RATE = 16,
    parameter int NUM_DATA_BITS   = 8,
    parameter int PARITY_ON       = 1,
    parameter int PARITY_EO       = 1,
    parameter int NUM_STOP_BITS   = 1,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_rx,
    output logic [NUM_DATA_BITS-1:0] o_data,
    output logic                     o_parity_err,
    output logic                     o_frame_err,
    output logic                     o_break,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_overrun
);

    localparam longint TICK_DEN = longint'(BAUD_RATE) * longint'(OVERSAMPLE_RATE);
    localparam longint DIV_CALC = (longint'(CLK_FREQ_HZ) + TICK_DEN / 2) / TICK_DEN;
    localparam int     DIV      = (DIV_CALC < 1) ? 1 : int'(DIV_CALC);
    localparam int     DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int     TW       = $clog2(OVERSAMPLE_RATE);
    localparam int     IW       = $clog2(NUM_DATA_BITS);
    localparam int     AW       = $clog2(FIFO_DEPTH);
    localparam int     EW       = NUM_DATA_BITS + 3;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TW-1:0]    T_PRE     = TW'(OVERSAMPLE_RATE / 2 - 1);
    localparam logic [TW-1:0]    T_MID     = TW'(OVERSAMPLE_RATE / 2);
    localparam logic [TW-1:0]    T_DEC     = TW'(OVERSAMPLE_RATE / 2 + 1);
    localparam logic [TW-1:0]    T_LAST    = TW'(OVERSAMPLE_RATE - 1);
    localparam logic [IW-1:0]    IDX_LAST  = IW'(NUM_DATA_BITS - 1);
    localparam logic             STOP_LAST = (NUM_STOP_BITS == 2);
    localparam logic             PAR_ODD   = (PARITY_EO != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK_WAIT
    } state_t;

    logic [1:0]               sync_reg;
    logic                     rx;
    state_t                   state_reg, state_next;
    logic [DIV_W-1:0]         div_cnt_reg, div_cnt_next;
    logic [TW-1:0]            tcnt_reg, tcnt_next;
    logic [IW-1:0]            idx_reg, idx_next;
    logic                     stop_idx_reg, stop_idx_next;
    logic                     s0_reg, s0_next;
    logic                     s1_reg, s1_next;
    logic [NUM_DATA_BITS-1:0] shift_reg, shift_next;
    logic                     par_bit_reg, par_bit_next;
    logic                     par_err_reg, par_err_next;
    logic                     frame_err_reg, frame_err_next;
    logic                     wr_en_reg, wr_en_next;
    logic [EW-1:0]            wr_entry_reg, wr_entry_next;

    logic tick;
    logic majority;
    logic frame_err_now;
    logic brk_now;
    logic bit_active;

    assign rx            = sync_reg[1];
    assign tick          = (div_cnt_reg == DIV_LAST);
    assign majority      = (s0_reg & s1_reg) | (s0_reg & rx) | (s1_reg & rx);
    assign frame_err_now = frame_err_reg | ~majority;
    assign brk_now       = (shift_reg == '0) && !par_bit_reg && frame_err_now;
    assign bit_active    = (state_reg != S_IDLE) && (state_reg != S_BREAK_WAIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_reg      <= 2'b11;
            state_reg     <= S_IDLE;
            div_cnt_reg   <= '0;
            tcnt_reg      <= '0;
            idx_reg       <= '0;
            stop_idx_reg  <= 1'b0;
            s0_reg        <= 1'b1;
            s1_reg        <= 1'b1;
            shift_reg     <= '0;
            par_bit_reg   <= 1'b0;
            par_err_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_entry_reg  <= '0;
        end else begin
            sync_reg      <= {sync_reg[0], i_rx};
            state_reg     <= state_next;
            div_cnt_reg   <= div_cnt_next;
            tcnt_reg      <= tcnt_next;
            idx_reg       <= idx_next;
            stop_idx_reg  <= stop_idx_next;
            s0_reg        <= s0_next;
            s1_reg        <= s1_next;
            shift_reg     <= shift_next;
            par_bit_reg   <= par_bit_next;
            par_err_reg   <= par_err_next;
            frame_err_reg <= frame_err_next;
            wr_en_reg     <= wr_en_next;
            wr_entry_reg  <= wr_entry_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        div_cnt_next   = div_cnt_reg;
        tcnt_next      = tcnt_reg;
        idx_next       = idx_reg;
        stop_idx_next  = stop_idx_reg;
        s0_next        = s0_reg;
        s1_next        = s1_reg;
        shift_next     = shift_reg;
        par_bit_next   = par_bit_reg;
        par_err_next   = par_err_reg;
        frame_err_next = frame_err_reg;
        wr_en_next     = 1'b0;
        wr_entry_next  = wr_entry_reg;

        // Divider held at zero while waiting so tick phase aligns to the start edge.
        if (!bit_active || tick) begin
            div_cnt_next = '0;
        end else begin
            div_cnt_next = div_cnt_reg + 1'b1;
        end

        if (bit_active && tick) begin
            if (tcnt_reg == T_PRE) s0_next = rx;
            if (tcnt_reg == T_MID) s1_next = rx;
            tcnt_next = (tcnt_reg == T_LAST) ? '0 : tcnt_reg + 1'b1;
        end

        case (state_reg)
            S_IDLE: begin
                tcnt_next      = '0;
                idx_next       = '0;
                stop_idx_next  = 1'b0;
                par_bit_next   = 1'b0;
                par_err_next   = 1'b0;
                frame_err_next = 1'b0;
                if (!rx) state_next = S_START;
            end
            S_START: begin
                if (tick) begin
                    if (tcnt_reg == T_DEC && majority) begin
                        state_next = S_IDLE;
                    end else if (tcnt_reg == T_LAST) begin
                        state_next = S_DATA;
                        idx_next   = '0;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (tcnt_reg == T_DEC) begin
                        shift_next = {majority, shift_reg[NUM_DATA_BITS-1:1]};
                    end
                    if (tcnt_reg == T_LAST) begin
                        if (idx_reg == IDX_LAST) begin
                            state_next    = (PARITY_ON != 0) ? S_PARITY : S_STOP;
                            stop_idx_next = 1'b0;
                        end else begin
                            idx_next = idx_reg + 1'b1;
                        end
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    if (tcnt_reg == T_DEC) begin
                        par_bit_next = majority;
                        par_err_next = ((^shift_reg) ^ majority) != PAR_ODD;
                    end
                    if (tcnt_reg == T_LAST) state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (tcnt_reg == T_DEC) begin
                        frame_err_next = frame_err_now;
                        // Last stop bit decided: emit now rather than waiting out the bit.
                        if (stop_idx_reg == STOP_LAST) begin
                            wr_en_next    = 1'b1;
                            wr_entry_next = {brk_now, frame_err_now, par_err_reg, shift_reg};
                            state_next    = brk_now ? S_BREAK_WAIT : S_IDLE;
                        end
                    end
                    if (tcnt_reg == T_LAST) stop_idx_next = 1'b1;
                end
            end
            S_BREAK_WAIT: begin
                if (rx) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
    logic          overrun_reg;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic [EW-1:0] head;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                        (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign pop        = !fifo_empty && i_ready;
    assign push       = wr_en_reg && (!fifo_full || pop);
    assign head       = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr_reg[AW-1:0]] <= wr_entry_reg;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            overrun_reg <= wr_en_reg && fifo_full && !pop;
        end
    end

    // Storage is not reset, so outputs are masked to zero while the FIFO is empty.
    assign o_valid   = !fifo_empty;
    assign o_overrun = overrun_reg;
    assign {o_break, o_frame_err, o_parity_err, o_data} = fifo_empty ? '0 : head;

endmodule

// File: doc/uart_rx_ovs.md
# uart_rx_ovs

Parametrised UART receiver with majority-vote oversampling, selectable stop-bit count, framing/parity/break detection and an output FIFO with valid/ready handshake. It sits between the asynchronous RX pin and any byte-consuming logic. It replaces single-sample, no-buffer reception with glitch-tolerant sampling, so that back-pressure from the consumer never loses a byte silently.

## Interface
- CLK_FREQ_HZ, 100_000_000, system clock frequency
- BAUD_RATE, 1_562_500, line baud rate
- OVERSAMPLE_RATE, 16, ticks per bit; 8 or 16 only
- NUM_DATA_BITS, 8, data bits per frame; 5..9
- PARITY_ON, 1, 0 = no parity bit, 1 = parity bit present
- PARITY_EO, 1, 0 = even, 1 = odd
- NUM_STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 4, entries; power of 2, ≥2
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset; one clock domain
- i_rx  in  1  asynchronous serial line, idle high
- o_data  out  NUM_DATA_BITS  head-of-FIFO data, LSB first on line
- o_parity_err  out  1  head entry parity mismatch (0 when PARITY_ON=0)
- o_frame_err  out  1  head entry stop bit sampled 0
- o_break  out  1  head entry is a break condition
- o_valid  out  1  FIFO not empty
- i_ready  in  1  consumer accepts head entry when o_valid & i_ready
- o_overrun  out  1  one-cycle pulse: completed frame dropped, FIFO full

## Operation
- i_rx passes through a 2-flop synchroniser; both flops reset to 1. All logic below uses the synchronised value rx.
- Tick divider: DIV = round(CLK_FREQ_HZ / (BAUD_RATE*OVERSAMPLE_RATE)), minimum 1. A tick pulses every DIV clocks. The divider is cleared in IDLE, so phase aligns to the detected start edge.
- Tick counter tcnt (0..OVERSAMPLE_RATE-1) per bit. The bit value is the majority of rx at ticks M-1, M and M+1, where M = OVERSAMPLE_RATE/2.
- FSM states:
  - IDLE: on rx=0, go to START with tcnt=0.
  - START: at tick M+1, majority=1 means false start → IDLE with no entry. Otherwise continue, and at tick OVERSAMPLE_RATE-1 go to DATA with idx=0.
  - DATA: shift the majority bit in LSB first at tick M+1. At end of bit, idx++. After bit NUM_DATA_BITS-1 go to PARITY if PARITY_ON, else STOP.
  - PARITY: parity_err = (^data ^ bit) != PARITY_EO. Go to STOP at end of bit.
  - STOP: sample each stop bit. frame_err = any stop sample 0. Once the last stop bit is decided at tick M+1, the frame completes in that cycle:
    - break = data all 0, parity bit 0 (or absent), frame_err.
    - If break → BREAK_WAIT, else → IDLE. The remaining half stop bit is not waited out, which allows resync on back-to-back frames.
  - BREAK_WAIT: stay until rx=1, then → IDLE. Exactly one entry is produced per break.
- Completed frame write: push {break, frame_err, parity_err, data} if FIFO not full. If full, drop it and pulse o_overrun.
- Parity and frame errors do not suppress the write; the entry carries the flags.
- FIFO is show-ahead: outputs reflect mem[rd_ptr] whenever o_valid=1, and read occurs on o_valid & i_ready.
  - Pointers are log2(FIFO_DEPTH)+1 bits with an MSB wrap bit. Full is addresses equal with wrap bits differing.
  - Simultaneous push and pop when full: the pop frees a slot, so the push succeeds with no overrun.
  - Simultaneous push and pop when empty: the pop is ignored because o_valid=0.

## Timing
- Reset (asynchronous, any time including mid-frame): FSM to IDLE; all counters 0; FIFO empty; o_valid=0, o_overrun=0, o_data=0, all flags 0. No partial frame survives.
- Bit period = DIV*OVERSAMPLE_RATE clocks (64 at defaults).
- Start detect latency: 2 clocks (synchroniser) from the i_rx falling edge.
- Entry write occurs in the cycle after the final stop-bit decision. o_valid rises 1 clock after the write, roughly 2 + (1+N+P+S-0.5)*bit period after the start edge, where N, P, S are data, parity and stop bit counts.
- o_valid stays high and o_data/flags stay stable while i_ready=0.
- After the pop cycle, the next entry or o_valid=0 appears on the next clock.
- o_overrun is high for exactly 1 clock per dropped frame.

## Test plan
- Defaults, send 0xA5 with odd parity bit 1 and 1 stop bit, i_ready=1 → one entry: o_data=0xA5, all flags 0, o_valid high for 1 clock.
- Send 0x3C with parity bit inverted → o_data=0x3C, o_parity_err=1, o_frame_err=0. Then send 0x3C with the stop bit driven 0 → o_frame_err=1.
- Glitch rejection:
  - Drive i_rx low for 16 clocks (quarter bit) → no entry, FSM back in IDLE.
  - Inject a single-clock inverted glitch at tick M of data bit 3 while sending 0x00 → o_data=0x00.
- Break: hold i_rx low for 12 bit periods, then high → exactly one entry: o_data=0, o_break=1, o_frame_err=1.
- Overrun and reset:
  - FIFO_DEPTH=4, i_ready=0, send 0x01..0x05 back-to-back → one o_overrun pulse after the 5th frame. Raising i_ready drains 0x01..0x04 in order.
  - Assert i_rst_n low mid-frame → o_valid=0 immediately, no entry after release, and the next full frame is received correctly.
- Configuration sweep: NUM_DATA_BITS=5, PARITY_ON=0, NUM_STOP_BITS=2, OVERSAMPLE_RATE=8, send 0x15 then 0x0A back-to-back → both entries correct, flags 0. With the second stop bit driven 0 → o_frame_err=1.
